// File: rtl/i2c_regbank_pkg.sv
// Shared types and constants for the I2C register-bank target: FSM state encoding,
// ACK/NACK line levels and the bit-counter width.
package i2c_regbank_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_REG       = 4'd3,
        ST_REG_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_WAIT      = 4'd9
    } state_t;

    localparam logic BIT_ACK  = 1'b0;
    localparam logic BIT_NACK = 1'b1;

    localparam int BIT_CNT_W = 3;

endpackage

// File: rtl/i2c_regbank_line_sync.sv
// SCL/SDA two-flop synchronisers plus one history flop; decodes SCL edges and
// START/STOP conditions from the synchronised samples.
module i2c_regbank_line_sync (
    input  logic I_clk,
    input  logic I_rst,
    input  logic I_scl,
    input  logic I_sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_s
);

    // bits [1:0] are the synchroniser, bit [2] holds the previous synchronised sample
    logic [2:0] scl_q, scl_d;
    logic [2:0] sda_q, sda_d;

    always_comb begin
        scl_d = {scl_q[1:0], I_scl};
        sda_d = {sda_q[1:0], I_sda};
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= scl_d;
            sda_q <= sda_d;
        end
    end

    assign scl_rise = scl_q[1] & ~scl_q[2];
    assign scl_fall = ~scl_q[1] & scl_q[2];
    assign start    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
    assign stop     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
    assign sda_s    = sda_q[1];

endmodule

// File: rtl/i2c_regbank.sv
// I2C target register bank: indexed multi-byte registers with atomic commit and read snapshot.
// Define I2C_REGBANK_AUTOINC_EN to advance the register pointer after each complete register.
module i2c_regbank
    import i2c_regbank_pkg::*;
#(
    parameter int                          NREG      = 8,
    parameter int                          REG_BYTES = 3,
    parameter logic [2:0]                  ADDR_LSB  = 3'b100,
    parameter logic [NREG-1:0]             RO_MASK   = 8'b00000110,
    parameter logic [NREG*8*REG_BYTES-1:0] RST_VAL   = '0
) (
    input  logic                          I_clk,
    input  logic                          I_rst,
    input  logic                          I_scl,
    input  logic                          I_sda,
    output logic                          O_sda,
    output logic                          OE_sda,
    input  logic [3:0]                    I_myaddr,
    output logic [NREG*8*REG_BYTES-1:0]   O_regs,
    input  logic [NREG*8*REG_BYTES-1:0]   I_regs,
    output logic [NREG-1:0]               O_wstb,
    output logic                          O_busy,
    output state_t                        O_state
);

    localparam int W   = 8 * REG_BYTES;
    localparam int PW  = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int BCW = (REG_BYTES > 1) ? $clog2(REG_BYTES) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(REG_BYTES - 1);

    logic scl_rise, scl_fall, start, stop, sda_s;

    i2c_regbank_line_sync u_sync (
        .I_clk   (I_clk),
        .I_rst   (I_rst),
        .I_scl   (I_scl),
        .I_sda   (I_sda),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start   (start),
        .stop    (stop),
        .sda_s   (sda_s)
    );

    state_t                 state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [BCW-1:0]         byte_cnt_q, byte_cnt_d;
    logic [W-1:0]           shadow_q, shadow_d;
    logic [W-1:0]           snap_q, snap_d;
    logic [NREG*W-1:0]      regs_q, regs_d;
    logic [NREG-1:0]        wstb_q, wstb_d;
    logic                   oe_q, oe_d;
    logic                   busy_q, busy_d;
    logic                   phase_q, phase_d;
    logic                   rw_q, rw_d;

    logic [7:0]     rx_byte;
    logic           byte_done;
    logic           last_byte;
    logic [PW-1:0]  ptr_nxt;
    logic [PW-1:0]  rd_idx;
    logic [W-1:0]   rd_val;
    logic [W-1:0]   new_shadow;

    always_comb begin
        rx_byte   = {shift_q[6:0], sda_s};
        byte_done = scl_rise && (bit_cnt_q == '0);
        last_byte = (byte_cnt_q == LAST_BYTE);
`ifdef I2C_REGBANK_AUTOINC_EN
        ptr_nxt = (ptr_q == PW'(NREG - 1)) ? '0 : ptr_q + 1'b1;
`else
        ptr_nxt = ptr_q;
`endif
        // the next register is only fetched when a whole read register has been sent
        rd_idx = (state_q == ST_RDATA_ACK && last_byte) ? ptr_nxt : ptr_q;
        rd_val = RO_MASK[rd_idx] ? I_regs[int'(rd_idx)*W +: W] : regs_q[int'(rd_idx)*W +: W];
        new_shadow = shadow_q;
        new_shadow[(REG_BYTES - 1 - int'(byte_cnt_q))*8 +: 8] = rx_byte;
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        byte_cnt_d = byte_cnt_q;
        shadow_d   = shadow_q;
        snap_d     = snap_q;
        regs_d     = regs_q;
        wstb_d     = '0;
        oe_d       = oe_q;
        busy_d     = busy_q;
        phase_d    = phase_q;
        rw_d       = rw_q;

        if (start) begin
            state_d    = ST_ADDR;
            bit_cnt_d  = 3'd7;
            oe_d       = 1'b0;
            phase_d    = 1'b0;
            byte_cnt_d = '0;
        end else if (stop) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            phase_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                    if (byte_done) begin
                        phase_d = 1'b0;
                        if (rx_byte[7:1] == {I_myaddr, ADDR_LSB}) begin
                            state_d = ST_ADDR_ACK;
                            busy_d  = 1'b1;
                            rw_d    = rx_byte[0];
                        end else begin
                            state_d = ST_WAIT;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ST_REG: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                    if (byte_done) begin
                        phase_d = 1'b0;
                        if (32'(rx_byte) < NREG) begin
                            state_d    = ST_REG_ACK;
                            ptr_d      = rx_byte[PW-1:0];
                            byte_cnt_d = '0;
                        end else begin
                            state_d = ST_WAIT;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                    if (byte_done) begin
                        phase_d = 1'b0;
                        if (RO_MASK[ptr_q]) begin
                            state_d = ST_WAIT;
                            busy_d  = 1'b0;
                        end else begin
                            state_d  = ST_WDATA_ACK;
                            shadow_d = new_shadow;
                            if (last_byte) begin
                                // whole register lands in one cycle so consumers never see a torn value
                                regs_d[int'(ptr_q)*W +: W] = new_shadow;
                                wstb_d[ptr_q] = 1'b1;
                                byte_cnt_d    = '0;
                                ptr_d         = ptr_nxt;
                            end else begin
                                byte_cnt_d = byte_cnt_q + 1'b1;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
                    if (scl_fall && !phase_q) begin
                        oe_d = 1'b1;
                    end else if (scl_rise) begin
                        phase_d = 1'b1;
                    end else if (scl_fall && phase_q) begin
                        phase_d   = 1'b0;
                        bit_cnt_d = 3'd7;
                        oe_d      = 1'b0;
                        if (state_q == ST_ADDR_ACK && rw_q) begin
                            state_d    = ST_RDATA;
                            snap_d     = rd_val;
                            oe_d       = ~rd_val[W-1];
                            byte_cnt_d = '0;
                        end else if (state_q == ST_ADDR_ACK) begin
                            state_d = ST_REG;
                        end else begin
                            state_d = ST_WDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        if (bit_cnt_q == '0) begin
                            state_d = ST_RDATA_ACK;
                            phase_d = 1'b0;
                        end
                    end else if (scl_fall) begin
                        snap_d = {snap_q[W-2:0], 1'b0};
                        oe_d   = ~snap_q[W-2];
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_fall && !phase_q) begin
                        snap_d = {snap_q[W-2:0], 1'b0};
                        oe_d   = 1'b0;
                    end else if (scl_rise) begin
                        if (sda_s == BIT_ACK) begin
                            phase_d = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                            busy_d  = 1'b0;
                            oe_d    = 1'b0;
                        end
                    end else if (scl_fall && phase_q) begin
                        phase_d   = 1'b0;
                        bit_cnt_d = 3'd7;
                        state_d   = ST_RDATA;
                        if (last_byte) begin
                            ptr_d      = ptr_nxt;
                            snap_d     = rd_val;
                            byte_cnt_d = '0;
                            oe_d       = ~rd_val[W-1];
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                            oe_d       = ~snap_q[W-1];
                        end
                    end
                end
                ST_IDLE, ST_WAIT: begin
                    oe_d   = 1'b0;
                    busy_d = (state_q == ST_WAIT) ? 1'b0 : busy_q;
                end
                default: begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            byte_cnt_q <= '0;
            shadow_q   <= '0;
            snap_q     <= '0;
            regs_q     <= RST_VAL;
            wstb_q     <= '0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            phase_q    <= 1'b0;
            rw_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            byte_cnt_q <= byte_cnt_d;
            shadow_q   <= shadow_d;
            snap_q     <= snap_d;
            regs_q     <= regs_d;
            wstb_q     <= wstb_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            phase_q    <= phase_d;
            rw_q       <= rw_d;
        end
    end

    assign O_sda   = BIT_ACK;
    assign OE_sda  = oe_q;
    assign O_regs  = regs_q;
    assign O_wstb  = wstb_q;
    assign O_busy  = busy_q;
    assign O_state = state_q;

endmodule

// File: tb/tb_i2c_regbank.sv
// Bench for i2c_regbank: bit-banged I2C master, register/strobe model and read-byte scoreboard.
module tb_i2c_regbank;
    import i2c_regbank_pkg::*;

    localparam int NREG = 8;
    localparam int RB   = 3;
    localparam int W    = 8 * RB;
    localparam int Q    = 8;
    localparam logic [NREG-1:0] RO = 8'b00000110;
    localparam logic [6:0] DEV_ADDR = 7'h1C;
`ifdef I2C_REGBANK_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              scl = 1'b1;
    logic              m_sda = 1'b1;
    logic              bus_sda;
    logic              o_sda, oe_sda, busy;
    logic [3:0]        myaddr = 4'h3;
    logic [NREG*W-1:0] o_regs, i_regs;
    logic [NREG-1:0]   wstb;
    state_t            dbg_state;

    logic [W-1:0] model [NREG];
    logic [7:0]   exp_q [$];
    int           exp_stb [$];
    int           stb_log [$];
    int           oe_cnt = 0;
    int           busy_cnt = 0;
    int           n_checks = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;
    assign bus_sda = m_sda & ~(oe_sda & ~o_sda);

    i2c_regbank dut (
        .I_clk   (clk),
        .I_rst   (rst),
        .I_scl   (scl),
        .I_sda   (bus_sda),
        .O_sda   (o_sda),
        .OE_sda  (oe_sda),
        .I_myaddr(myaddr),
        .O_regs  (o_regs),
        .I_regs  (i_regs),
        .O_wstb  (wstb),
        .O_busy  (busy),
        .O_state (dbg_state)
    );

    always @(negedge clk) begin
        for (int i = 0; i < NREG; i++) if (wstb[i]) stb_log.push_back(i);
        if (oe_sda) oe_cnt++;
        if (busy) busy_cnt++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rd_model(input int i);
        return RO[i] ? i_regs[i*W +: W] : model[i];
    endfunction

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; wait_q();
        scl = 1'b1;   wait_q();
        m_sda = 1'b0; wait_q();
        scl = 1'b0;   wait_q();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wait_q();
        scl = 1'b1;   wait_q();
        m_sda = 1'b1; wait_q();
    endtask

    task automatic put_bit(input logic b);
        m_sda = b;  wait_q();
        scl = 1'b1; wait_q();
        wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic get_bit(output logic b);
        m_sda = 1'b1; wait_q();
        scl = 1'b1;   wait_q();
        b = bus_sda;  wait_q();
        scl = 1'b0;   wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output bit ack);
        logic a;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(a);
        ack = ~a;
    endtask

    task automatic read_byte(output logic [7:0] d, input bit master_ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(master_ack ? 1'b0 : 1'b1);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NREG; i++)
            if (!RO[i]) check_eq($sformatf("%s_reg%0d", tag, i), 32'(o_regs[i*W +: W]), 32'(model[i]));
    endtask

    task automatic check_stb(input string tag, input int base);
        int n;
        n = stb_log.size() - base;
        check_eq({tag, "_stb_count"}, n, exp_stb.size());
        for (int i = 0; i < n && i < exp_stb.size(); i++)
            check_eq({tag, "_stb_index"}, stb_log[base + i], exp_stb[i]);
    endtask

    task automatic write_txn(input string tag, input logic [7:0] idx, input logic [47:0] data, input int n);
        bit ack;
        int ptr, k, base;
        logic [W-1:0] shadow;
        logic [7:0] b;
        base = stb_log.size();
        exp_stb.delete();
        shadow = '0;
        bus_start();
        write_byte({DEV_ADDR, 1'b0}, ack);
        check_eq({tag, "_addr_ack"}, 32'(ack), 1);
        write_byte(idx, ack);
        check_eq({tag, "_idx_ack"}, 32'(ack), 32'(int'(idx) < NREG));
        if (int'(idx) < NREG) begin
            ptr = int'(idx);
            k = 0;
            for (int j = 0; j < n; j++) begin
                b = data[8*(n-1-j) +: 8];
                write_byte(b, ack);
                check_eq({tag, "_data_ack"}, 32'(ack), 32'(!RO[ptr]));
                if (RO[ptr]) break;
                shadow[8*(RB-1-k) +: 8] = b;
                k++;
                if (k == RB) begin
                    model[ptr] = shadow;
                    exp_stb.push_back(ptr);
                    k = 0;
                    ptr = AUTOINC ? (ptr + 1) % NREG : ptr;
                end
            end
        end
        bus_stop();
        repeat (4) @(negedge clk);
        check_eq({tag, "_busy_idle"}, 32'(busy), 0);
        check_stb(tag, base);
        check_regs(tag);
    endtask

    task automatic read_txn(input string tag, input int idx, input int n);
        bit ack;
        int ptr, k;
        logic [W-1:0] v;
        logic [7:0] got, e;
        bus_start();
        write_byte({DEV_ADDR, 1'b0}, ack);
        check_eq({tag, "_waddr_ack"}, 32'(ack), 1);
        write_byte(8'(idx), ack);
        check_eq({tag, "_idx_ack"}, 32'(ack), 1);
        bus_start();
        write_byte({DEV_ADDR, 1'b1}, ack);
        check_eq({tag, "_raddr_ack"}, 32'(ack), 1);
        ptr = idx;
        k = 0;
        for (int j = 0; j < n; j++) begin
            v = rd_model(ptr);
            exp_q.push_back(v[8*(RB-1-k) +: 8]);
            read_byte(got, j < n - 1);
            e = exp_q.pop_front();
            check_eq($sformatf("%s_byte%0d", tag, j), 32'(got), 32'(e));
            k++;
            if (k == RB) begin
                k = 0;
                ptr = AUTOINC ? (ptr + 1) % NREG : ptr;
            end
        end
        repeat (4) @(negedge clk);
        check_eq({tag, "_release"}, 32'(oe_sda), 0);
        check_eq({tag, "_busy_nack"}, 32'(busy), 0);
        bus_stop();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bit ack;
        int oe0, busy0, base;
        logic [7:0] got;

        for (int i = 0; i < NREG; i++) begin
            i_regs[i*W +: W] = 24'hE0_0000 | 24'(i * 24'h000111);
            model[i] = '0;
        end
        i_regs[1*W +: W] = 24'hA5B6C7;
        i_regs[2*W +: W] = 24'h0D0E0F;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rst_oe", 32'(oe_sda), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_wstb", 32'(wstb), 0);
        check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check_regs("rst");

        write_txn("wr3", 8'h03, 48'h123456, 3);
        read_txn("rd3", 3, 3);

        // foreign address: target must stay off the bus
        oe0 = oe_cnt;
        busy0 = busy_cnt;
        base = stb_log.size();
        exp_stb.delete();
        bus_start();
        write_byte({7'h1E, 1'b0}, ack);
        check_eq("bad_addr_ack", 32'(ack), 0);
        write_byte(8'h03, ack);
        write_byte(8'h99, ack);
        bus_stop();
        repeat (4) @(negedge clk);
        check_eq("bad_addr_oe", oe_cnt - oe0, 0);
        check_eq("bad_addr_busy", busy_cnt - busy0, 0);
        check_stb("bad_addr", base);
        check_regs("bad_addr");

        write_txn("bad_idx", 8'h08, 48'h010203, 3);
        write_txn("ro1", 8'h01, 48'h777777, 3);
        read_txn("rd_ro1", 1, 3);
        write_txn("partial4", 8'h04, 48'hAABB, 2);
        write_txn("wr0", 8'h00, 48'hC0FFEE, 3);
        write_txn("wr6x2", 8'h06, 48'h112233445566, 6);
        read_txn("rd7x3", 7, 9);

        // reset while the target is driving a read bit low
        bus_start();
        write_byte({DEV_ADDR, 1'b0}, ack);
        write_byte(8'h03, ack);
        bus_start();
        write_byte({DEV_ADDR, 1'b1}, ack);
        check_eq("mid_rd_addr_ack", 32'(ack), 1);
        read_byte(got, 1'b1);
        check_eq("mid_rd_byte0", 32'(got), 32'h12);
        check_eq("mid_rd_drive", 32'(oe_sda), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rd_rst_release", 32'(oe_sda), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREG; i++) model[i] = '0;
        scl = 1'b1;
        wait_q();
        bus_stop();
        repeat (4) @(negedge clk);
        check_eq("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("post_rst_busy", 32'(busy), 0);
        check_regs("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
